genloop_accum: RTL and testbench
================================

Name: genloop_accum

Overview:
- Sequential accumulation stage fed by a handshaked operand stream.
- Sums groups of up to NUM unsigned WIDTH-bit operands per group.
- Each step uses a WIDTH-bit ripple-carry add with carry-out. The low WIDTH bits of the accumulator are added to the incoming operand, and the carry-out increments an 8-bit upper extension.
- The finished group sum is presented on a valid/ready output port to the downstream consumer.

Parameters:
- WIDTH, 8, operand width in bits; must be ≥ 1.
- NUM, 4, maximum operands per group; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  operand present.
- in_data  input  WIDTH  unsigned operand.
- in_last  input  1  operand closes the group early; qualified by in_valid.
- in_ready  output  1  stage accepts an operand this cycle.
- out_valid  output  1  group result valid.
- out_sum  output  WIDTH+8  group sum, modulo 2^(WIDTH+8).
- out_count  output  8  number of operands in the group.
- out_ready  input  1  consumer accepts the result.

Behaviour:
- **Reset.** While rst is high, asynchronously:
  - state=IDLE; acc=0; cnt=0.
  - out_valid=0, out_sum=0, out_count=0.
  - in_ready=1 (combinational from state).
  - Reset mid-group discards the partial sum; nothing is emitted.
- **Accept.** An operand is accepted when in_valid & in_ready at a rising clk edge.
- **Handshake rules.**
  - in_ready = (state != DONE); it does not depend on in_valid or out_ready.
  - in_data and in_last are ignored when not accepted.
- **States.**
  - IDLE: no partial group.
    - Accept → acc = {8'b0, in_data}; cnt = 1.
    - If in_last or NUM==1 → DONE; else → ACCUM.
  - ACCUM: partial group held.
    - Accept → acc[WIDTH-1:0] = low sum of acc[WIDTH-1:0] + in_data.
    - acc[WIDTH+7:WIDTH] increments by the carry-out, wrapping 255→0.
    - cnt = cnt + 1.
    - If in_last or the new cnt == NUM → DONE; else stay in ACCUM.
    - No accept → hold all state.
  - DONE: result held.
    - out_valid=1, out_sum=acc, out_count=cnt; all three are registers loaded on the transition into DONE.
    - Values are stable while out_valid & !out_ready.
    - On out_valid & out_ready → IDLE; out_valid=0 the next cycle.
    - out_sum and out_count keep their last values after the handshake (don't-care for the consumer).
- **Latency and throughput.**
  - out_valid rises on the edge that accepts the closing operand, so it is visible in the following cycle.
  - Minimum group period is cnt+1 cycles; an operand is never accepted in the cycle of the output handshake.
- **Arithmetic.**
  - Unsigned only.
  - Low-part carry-out is the standard ripple majority of a, b and the carry chain; bit 0 has carry-in 0.
  - The upper 8 bits count carries modulo 256. With NUM ≤ 255 the true sum always fits, so no overflow is possible.
- **Boundary cases.**
  - in_last on the first operand gives a 1-operand group: out_sum = operand, out_count = 1.
  - in_last together with cnt reaching NUM closes the group once (no double close).
  - out_ready held high while out_valid is low has no effect.

Test Plan:
- WIDTH=8, NUM=4; feed 0x10, 0x20, 0x30, 0x40 back-to-back with out_ready=1 → out_valid 1 cycle after the 4th accept, out_sum=0x0A0, out_count=4; in_ready low for exactly 1 cycle.
- Feed 0xFF ×4 → out_sum=0x3FC, out_count=4. This checks carry propagation into the upper bits on every step.
- Feed 0x05 with in_last=1 from IDLE → out_sum=0x005, out_count=1; the next group starts cleanly with acc reset.
- Group 0x01, 0x02, 0x03 done, out_ready held 0 for 5 cycles → out_valid, out_sum=0x006 and out_count=3 stable; in_ready=0 throughout; a pulsed in_valid is ignored; after out_ready=1 the next operand is accepted 1 cycle later.
- Assert rst for 1 cycle after 2 of 4 operands (0x80, 0x80) → out_valid stays 0; the following group 0x01 ×4 yields out_sum=0x004.
- NUM=1, WIDTH=4; feed 0xF, 0xF with out_ready=1 → two results, each out_sum=0x00F, out_count=1, accepted on alternate cycles.

Source files
------------

// File: rtl/genloop_accum.sv
// genloop_accum: groups up to NUM unsigned operands into one sum using a generated ripple-carry adder,
// with the carry-out counted in an 8-bit upper extension; the result is offered on a valid/ready port.
module genloop_accum #(
    parameter int WIDTH = 8,
    parameter int NUM   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH+7:0] out_sum,
    output logic [7:0]       out_count,
    input  logic             out_ready
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    localparam logic [7:0] NUM8 = 8'(NUM);
    state_t           state_q, state_d;
    logic [WIDTH+7:0] acc_q, acc_d, sum_q, sum_d;
    logic [7:0]       cnt_q, cnt_d, count_q, count_d, cnt_inc;
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;
    logic             accept;
    assign c[0] = 1'b0;
    for (genvar i = 0; i < WIDTH; i++) begin : g_rca
        assign s[i]   = acc_q[i] ^ in_data[i] ^ c[i];
        assign c[i+1] = (acc_q[i] & in_data[i]) | (acc_q[i] & c[i]) | (in_data[i] & c[i]);
    end
    assign in_ready  = state_q != DONE;
    assign accept    = in_valid & in_ready;
    assign cnt_inc   = cnt_q + 8'd1;
    assign out_valid = state_q == DONE;
    assign out_sum   = sum_q;
    assign out_count = count_q;
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        count_d = count_q;
        case (state_q)
            IDLE: if (accept) begin
                acc_d   = {8'b0, in_data};
                cnt_d   = 8'd1;
                state_d = (in_last || NUM == 1) ? DONE : ACCUM;
            end
            ACCUM: if (accept) begin
                acc_d   = {acc_q[WIDTH+7:WIDTH] + {7'b0, c[WIDTH]}, s};
                cnt_d   = cnt_inc;
                state_d = (in_last || cnt_inc == NUM8) ? DONE : ACCUM;
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        // result registers capture only on entry into DONE, so they stay frozen while stalled
        if (state_d == DONE && state_q != DONE) begin
            sum_d   = acc_d;
            count_d = cnt_d;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_genloop_accum.sv
// tb_genloop_accum: directed vector table plus hand sequences for stall, reset and NUM=1 cases.
module tb_genloop_accum;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a_valid = 1'b0, a_last = 1'b0, a_ready, a_ovalid, a_oready = 1'b0;
    logic [7:0] a_data = '0, a_count;
    logic [15:0] a_sum;
    logic b_valid = 1'b0, b_last = 1'b0, b_ready, b_ovalid, b_oready = 1'b0;
    logic [3:0] b_data = '0;
    logic [7:0] b_count;
    logic [11:0] b_sum;
    int total = 0, passed = 0;

    always #5 clk = ~clk;

    genloop_accum #(.WIDTH(8), .NUM(4)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_data(a_data), .in_last(a_last),
        .in_ready(a_ready), .out_valid(a_ovalid), .out_sum(a_sum), .out_count(a_count),
        .out_ready(a_oready));

    genloop_accum #(.WIDTH(4), .NUM(1)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_data(b_data), .in_last(b_last),
        .in_ready(b_ready), .out_valid(b_ovalid), .out_sum(b_sum), .out_count(b_count),
        .out_ready(b_oready));

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic        r;
        logic        er;
        logic        ev;
        logic [15:0] es;
        logic [7:0]  ec;
    } vec_t;
    vec_t tbl[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step_a(input string nm, input logic v, input logic [7:0] d, input logic l,
                          input logic r, input logic er, input logic ev,
                          input logic [15:0] es, input logic [7:0] ec);
        @(negedge clk);
        a_valid = v; a_data = d; a_last = l; a_oready = r;
        #1;
        chk({nm, ".in_ready"}, 32'(a_ready), 32'(er));
        chk({nm, ".out_valid"}, 32'(a_ovalid), 32'(ev));
        if (ev) begin
            chk({nm, ".out_sum"}, 32'(a_sum), 32'(es));
            chk({nm, ".out_count"}, 32'(a_count), 32'(ec));
        end
    endtask

    task automatic step_b(input string nm, input logic v, input logic [3:0] d, input logic er,
                          input logic ev, input logic [11:0] es, input logic [7:0] ec);
        @(negedge clk);
        b_valid = v; b_data = d; b_last = 1'b0; b_oready = 1'b1;
        #1;
        chk({nm, ".in_ready"}, 32'(b_ready), 32'(er));
        chk({nm, ".out_valid"}, 32'(b_ovalid), 32'(ev));
        if (ev) begin
            chk({nm, ".out_sum"}, 32'(b_sum), 32'(es));
            chk({nm, ".out_count"}, 32'(b_count), 32'(ec));
        end
    endtask

    initial begin
        //          v     d      l     r     er    ev    sum       cnt
        tbl[0]  = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b1, 1'b0, 16'h000, 8'd0};
        tbl[1]  = '{1'b1, 8'h20, 1'b0, 1'b1, 1'b1, 1'b0, 16'h000, 8'd0};
        tbl[2]  = '{1'b1, 8'h30, 1'b0, 1'b1, 1'b1, 1'b0, 16'h000, 8'd0};
        tbl[3]  = '{1'b1, 8'h40, 1'b0, 1'b1, 1'b1, 1'b0, 16'h000, 8'd0};
        tbl[4]  = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0A0, 8'd4};
        tbl[5]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 16'h000, 8'd0};
        tbl[6]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 16'h000, 8'd0};
        tbl[7]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 16'h000, 8'd0};
        tbl[8]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 16'h000, 8'd0};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 16'h3FC, 8'd4};
        tbl[10] = '{1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 1'b0, 16'h000, 8'd0};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 16'h005, 8'd1};
        tbl[12] = '{1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 16'h000, 8'd0};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 16'h007, 8'd1};
        tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 16'h000, 8'd0};

        #1;
        chk("reset.in_ready", 32'(a_ready), 32'd1);
        chk("reset.out_valid", 32'(a_ovalid), 32'd0);
        chk("reset.out_sum", 32'(a_sum), 32'd0);
        chk("reset.out_count", 32'(a_count), 32'd0);
        chk("reset.b_out_valid", 32'(b_ovalid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 15; k++)
            step_a($sformatf("tbl%0d", k), tbl[k].v, tbl[k].d, tbl[k].l, tbl[k].r,
                   tbl[k].er, tbl[k].ev, tbl[k].es, tbl[k].ec);

        step_a("bp_op1", 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 8'd0);
        step_a("bp_op2", 1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 8'd0);
        step_a("bp_op3", 1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 8'd0);
        for (int k = 0; k < 5; k++)
            step_a($sformatf("bp_stall%0d", k), k == 2, 8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 16'h006, 8'd3);
        step_a("bp_release", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 16'h006, 8'd3);
        step_a("bp_next", 1'b1, 8'h09, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 8'd0);
        step_a("bp_next_res", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 16'h009, 8'd1);

        step_a("rst_op1", 1'b1, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 8'd0);
        step_a("rst_op2", 1'b1, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 8'd0);
        @(negedge clk);
        a_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid.out_valid", 32'(a_ovalid), 32'd0);
        chk("rst_mid.in_ready", 32'(a_ready), 32'd1);
        chk("rst_mid.out_sum", 32'(a_sum), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_after.out_valid", 32'(a_ovalid), 32'd0);
        for (int k = 0; k < 4; k++)
            step_a($sformatf("rst_grp%0d", k), 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 8'd0);
        step_a("rst_grp_res", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 16'h004, 8'd4);

        step_b("n1_a", 1'b1, 4'hF, 1'b1, 1'b0, 12'h0, 8'd0);
        step_b("n1_b", 1'b1, 4'hF, 1'b0, 1'b1, 12'h00F, 8'd1);
        step_b("n1_c", 1'b1, 4'hF, 1'b1, 1'b0, 12'h0, 8'd0);
        step_b("n1_d", 1'b0, 4'h0, 1'b0, 1'b1, 12'h00F, 8'd1);
        step_b("n1_e", 1'b0, 4'h0, 1'b1, 1'b0, 12'h0, 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
